// File: rtl/red_pitaya_prbs_gen_if.sv
// Bus and sample-stream bundle for red_pitaya_prbs_gen.
// Stream handshake: a sample moves on a clock edge where valid_o && ready_i; valid_o and dat_o hold until then.
interface red_pitaya_prbs_gen_if #(
    parameter int NCH = 2,
    parameter int DW  = 14
);
    logic [31:0]       sys_addr_i;
    logic [31:0]       sys_wdata_i;
    logic [3:0]        sys_sel_i;
    logic              sys_wen_i;
    logic              sys_ren_i;
    logic [31:0]       sys_rdata_o;
    logic              sys_err_o;
    logic              sys_ack_o;
    logic [NCH*DW-1:0] dat_o;
    logic              valid_o;
    logic              ready_i;

    modport master (
        output sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i, ready_i,
        input  sys_rdata_o, sys_err_o, sys_ack_o, dat_o, valid_o
    );

    modport slave (
        input  sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i, ready_i,
        output sys_rdata_o, sys_err_o, sys_ack_o, dat_o, valid_o
    );
endinterface

// File: rtl/red_pitaya_prbs_gen.sv
// Multi-channel Galois-LFSR pattern generator with bus-programmable run control.
// Defining PRBS_CHK_EN adds a loopback bit-error checker that tracks channel 0.
module red_pitaya_prbs_gen #(
    parameter int          NCH      = 2,
    parameter int          DW       = 14,
    parameter logic [31:0] POLY_RST = 32'h84C11DB6,
    parameter logic [31:0] SEED_RST = 32'h01010101
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    red_pitaya_prbs_gen_if.slave bus,
    output logic                 busy_o,
    output logic [1:0]           state_o,
    input  logic [DW-1:0]        chk_dat_i,
    input  logic                 chk_valid_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state;
    logic              mode, reseed, seeded;
    logic [31:0]       burst_len, poly, sample_cnt, chk_err;
    logic [15:0]       div, div_cnt, drop_cnt;
    logic [31:0]       seed    [NCH];
    logic [31:0]       lfsr    [NCH];
    logic [31:0]       lfsr_nx [NCH];
    logic [DW-1:0]     smp     [NCH];
    logic              valid;
    logic [NCH*DW-1:0] dat;
    logic [19:0]       addr;
    logic [31:0]       wdata, rd;
    logic              hit, wr_ctrl, start_cmd, stop_cmd;
    logic              xfer, pend, tick, burst_end, load_smp;
    logic              ack, err;
    logic [31:0]       rdata;
    logic              unused_in;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] p);
        logic [31:0] t;
        t = s ^ (p & {32{s[0]}});
        return {s[0], t[31:1]};
    endfunction

    assign addr      = bus.sys_addr_i[19:0];
    assign wdata     = bus.sys_wdata_i;
    assign wr_ctrl   = bus.sys_wen_i && (addr == 20'h0);
    assign stop_cmd  = wr_ctrl && wdata[1];
    assign start_cmd = wr_ctrl && wdata[0] && !wdata[1] && (state == ST_IDLE || state == ST_DONE);
    assign xfer      = valid && bus.ready_i;
    assign pend      = valid && !xfer;
    assign tick      = (state == ST_RUN) && (div_cnt >= div);
    // Burst ends either on the last transfer or immediately when nothing is left to send (BURST_LEN=0).
    assign burst_end = (state == ST_RUN) && mode &&
                       ((sample_cnt >= burst_len) || (xfer && (sample_cnt + 32'd1 >= burst_len)));
    assign load_smp  = tick && !pend && !stop_cmd && !burst_end;

    assign busy_o      = (state == ST_RUN) || (state == ST_DRAIN);
    assign state_o     = state;
    assign bus.dat_o   = dat;
    assign bus.valid_o = valid;
    assign bus.sys_ack_o   = ack;
    assign bus.sys_err_o   = err;
    assign bus.sys_rdata_o = rdata;

    // A sample loaded in the same cycle as a transfer must come from the stepped state.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            lfsr_nx[c] = lfsr_step(lfsr[c], poly);
            smp[c]     = xfer ? lfsr_nx[c][DW-1:0] : lfsr[c][DW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            mode       <= 1'b0;
            reseed     <= 1'b0;
            seeded     <= 1'b0;
            burst_len  <= '0;
            div        <= '0;
            poly       <= POLY_RST;
            sample_cnt <= '0;
            div_cnt    <= '0;
            drop_cnt   <= '0;
            valid      <= 1'b0;
            dat        <= '0;
            for (int c = 0; c < NCH; c++) begin
                seed[c] <= SEED_RST;
                lfsr[c] <= '0;
            end
        end else begin
            if (bus.sys_wen_i) begin
                case (addr)
                    20'h00: begin
                        mode   <= wdata[2];
                        reseed <= wdata[3];
                    end
                    20'h08: burst_len <= wdata;
                    20'h0C: div       <= wdata[15:0];
                    20'h44: poly      <= wdata;
                    default: begin
                        for (int c = 0; c < NCH; c++)
                            if (addr == 20'(16 + 4 * c))
                                seed[c] <= (wdata == 32'h0) ? 32'h1 : wdata;
                    end
                endcase
            end

            if (state == ST_RUN) div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            if (tick && pend && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

            if (xfer) begin
                valid      <= 1'b0;
                sample_cnt <= sample_cnt + 32'd1;
                for (int c = 0; c < NCH; c++) lfsr[c] <= lfsr_nx[c];
            end
            if (load_smp) begin
                valid <= 1'b1;
                for (int c = 0; c < NCH; c++) dat[c*DW +: DW] <= smp[c];
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (stop_cmd) begin
                        state <= ST_IDLE;
                    end else if (start_cmd) begin
                        state      <= ST_RUN;
                        sample_cnt <= '0;
                        div_cnt    <= '0;
                        drop_cnt   <= '0;
                        seeded     <= 1'b1;
                        for (int c = 0; c < NCH; c++)
                            if (wdata[3] || !seeded) lfsr[c] <= seed[c];
                    end
                end
                ST_RUN: begin
                    if (stop_cmd) begin
                        state <= ST_DRAIN;
                    end else if (burst_end) begin
                        state <= ST_DONE;
                        valid <= 1'b0;
                    end
                end
                ST_DRAIN: if (!pend) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef PRBS_CHK_EN
    logic [31:0] chk_ref;
    logic [32:0] chk_sum;

    function automatic logic [5:0] popcnt(input logic [DW-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < DW; i++) n = n + 6'(v[i]);
        return n;
    endfunction

    assign chk_sum = {1'b0, chk_err} + 33'(popcnt(chk_dat_i ^ chk_ref[DW-1:0]));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chk_ref <= SEED_RST;
            chk_err <= '0;
        end else if (start_cmd) begin
            chk_ref <= seed[0];
            chk_err <= '0;
        end else begin
            if (bus.sys_wen_i && addr == 20'h4C && wdata[0])
                chk_err <= '0;
            else if (chk_valid_i)
                chk_err <= chk_sum[32] ? 32'hFFFF_FFFF : chk_sum[31:0];
            if (chk_valid_i) chk_ref <= lfsr_step(chk_ref, poly);
        end
    end

    assign unused_in = ^{bus.sys_sel_i, bus.sys_addr_i[31:20]};
`else
    assign chk_err   = '0;
    assign unused_in = ^{bus.sys_sel_i, bus.sys_addr_i[31:20], chk_dat_i, chk_valid_i};
`endif

    always_comb begin
        hit = 1'b1;
        rd  = '0;
        case (addr)
            20'h00: rd = {28'h0, reseed, mode, 2'b00};
            20'h04: rd = {drop_cnt, 14'h0, state == ST_DONE, busy_o};
            20'h08: rd = burst_len;
            20'h0C: rd = {16'h0, div};
            20'h40: rd = sample_cnt;
            20'h44: rd = poly;
            20'h48: rd = chk_err;
            20'h4C: rd = '0;
            default: begin
                hit = 1'b0;
                for (int c = 0; c < NCH; c++)
                    if (addr == 20'(16 + 4 * c)) begin
                        hit = 1'b1;
                        rd  = seed[c];
                    end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= bus.sys_wen_i || bus.sys_ren_i;
            err   <= (bus.sys_wen_i || bus.sys_ren_i) && !hit;
            rdata <= (bus.sys_ren_i && hit) ? rd : 32'h0;
        end
    end

endmodule
